cpu_ctrl_fsm: RTL and testbench
===============================

# cpu_ctrl_fsm

Synthesizable fetch/decode/execute controller for the 32-bit accumulator CPU. It owns PC, IR, MBR and AC, and sequences the single-port synchronous RAM and the external `alu` through a Moore state machine. The RAM is shared with the program loader, which owns it whenever `busy` is low. It replaces hand-written per-cycle stimulus sequencing with one RTL block.

## Interface
- `ADDR_WIDTH`, 28: RAM address width; PC width.
- `DATA_WIDTH`, 32: word, IR, MBR and AC width.
- `RESET_PC`, 'h100: PC value after reset.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, asynchronous, active-low; one clock domain.
- `start`  in  1: one-cycle pulse; leave IDLE/HALT and begin fetching at current PC.
- `mem_addr`  out  ADDR_WIDTH: RAM address.
- `mem_cs`, `mem_oe`, `mem_we`  out  1 each: RAM controls.
- `mem_wdata`  out  DATA_WIDTH: store data. Parent drives the tri-state bus when `mem_we`.
- `mem_rdata`  in  DATA_WIDTH: RAM read data, valid the cycle after address/cs/oe are presented.
- `alu_a`, `alu_b`  out  32: registered ALU operands.
- `alu_sel`  out  3: 000 AND, 001 ADD, 010 SUB, 100 OR.
- `alu_out`  in  32: combinational ALU result.
- `busy`  out  1: high in every state except IDLE and HALT.
- `halted`  out  1: high in HALT.
- `illegal`  out  1: sticky; set on an undefined opcode, cleared by `start`.
- `pc`  out  ADDR_WIDTH, `ac`  out  32, `ir`  out  32: observation.

## Operation
- Instruction format: IR[31] is the immediate flag, IR[30:27] the opcode, IR[11:0] the address or immediate (zero-extended).
- Opcodes:
  - 0000 ADD, 0001 HALT, 0010 LOAD, 0011 STORE, 0100 CLEAR, 0101 SKIPCOND, 0110 JUMP, 0111 SUB, 1000 AND, 1001 OR, 1010 NOT.
  - Immediate forms are defined only for ADD, SUB, AND, OR.
  - Any other combination is illegal: set `illegal` and treat as a no-op.
- States: IDLE, FETCH, LDIR, DEC, OPA, OPD, EXE, WB, ST, HALT.
- IDLE: controller outputs are quiet (`mem_cs`=0). `start` moves to FETCH.
- FETCH: `mem_addr`=pc, cs=oe=1, we=0. Then LDIR.
- LDIR: IR<=mem_rdata; PC<=PC+2. Then DEC.
- DEC executes single-cycle ops, then returns to FETCH:
  - CLEAR: AC<=0.
  - NOT: AC<=~AC.
  - JUMP: PC<=IR[11:0].
  - SKIPCOND: PC<=PC+2 when the condition holds. Selector IR[11:10]: 00 AC<0 (signed), 01 AC==0, 10 AC>0 (signed), 11 never.
  - HALT: go to HALT.
  - Illegal: no-op.
- Memory ALU ops (ADD/SUB/AND/OR, IR[31]=0): DEC → OPA → OPD → EXE → WB.
  - OPA: `mem_addr`=IR[11:0], read.
  - OPD: MBR<=mem_rdata.
  - EXE: alu_a<=AC, alu_b<=MBR, alu_sel set.
  - WB: AC<=alu_out.
- Immediate ALU ops: DEC → EXE (alu_b<=zero-extended IR[11:0]) → WB.
- LOAD: DEC → OPA → OPD → WB, with AC<=MBR.
- STORE: DEC → ST. ST drives `mem_addr`=IR[11:0], cs=we=1, oe=0, `mem_wdata`=AC. Then FETCH.
- HALT: PC stays at halt address + 2. `start` resumes from there.
- `start` while busy: ignored.
- Arithmetic is modulo 2^32. PC wraps modulo 2^ADDR_WIDTH.

## Timing
- Memory outputs are Moore-decoded from state and registers: no combinational path from `mem_rdata` or `alu_out` to any output.
- Reset values:
  - state IDLE, pc=RESET_PC.
  - ac, ir, MBR, alu_a, alu_b = 0; alu_sel=000.
  - mem_cs, mem_oe, mem_we = 0; mem_addr=0, mem_wdata=0.
  - busy, halted, illegal = 0.
- Instruction latency, counted as cycles from entering FETCH to the next FETCH:
  - CLEAR/NOT/JUMP/SKIPCOND/illegal: 3.
  - STORE: 4.
  - Immediate ALU: 5.
  - LOAD: 6.
  - Memory ALU: 7.
  - HALT: 3 cycles to enter HALT.
- `start` in IDLE: FETCH on the next edge, `busy` high in that cycle.
- Reset asserted mid-operation: all outputs go to reset values immediately, including mid-ST (`mem_we` drops asynchronously). No partial instruction state survives.

## Structure
- `cpu_pkg` holds:
  - opcode enum (4-bit);
  - state enum;
  - ALU select constants (AND/ADD/SUB/OR);
  - skip-condition encodings;
  - `RESET_PC` default.
- Sub-module `cpu_decoder`: combinational; IR → {opcode class, is_imm, alu_sel, illegal}. The FSM and registers live in `cpu_ctrl_fsm`.

## Test plan
- Reset: hold `rst_n`=0 → pc=0x100, ac=0, mem_cs=0, busy=0, halted=0. Pulse `start` → FETCH with mem_addr=0x100.
- Program with mem[0x120]=5, mem[0x122]=7:
  - mem[0x100]=0x10000120 (LOAD), [0x102]=0x00000122 (ADD), [0x104]=0x18000124 (STORE), [0x106]=0x08000000 (HALT).
  - Required: mem[0x124]=12, ac=12, halted after exactly 20 cycles, pc=0x108.
- Immediate/skip:
  - AC=0, then 0x8000000A (ADDI) → ac=0x0A; then 0xB800000B (SUBI) → ac=0xFFFFFFFF.
  - Then 0x28000000 (SKIPCOND 00) skips the next word; pc advances by 4.
  - With AC=0, 0x28000800 (SKIPCOND 10) does not skip.
- JUMP 0x30000200 → pc=0x200 after 3 cycles; next fetch mem_addr=0x200.
- Illegal 0xF8000000 → illegal=1, ac unchanged, pc+2. A later `start` clears `illegal`.
- Reset pulse during ST of a STORE → mem_we=0 at once, target word unchanged, state IDLE, pc=0x100.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU controller:
// opcodes, FSM states, decoded instruction classes, ALU selects and
// skip-condition encodings.
package cpu_pkg;

    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0100;

    typedef enum logic [3:0] {
        OP_ADD      = 4'b0000,
        OP_HALT     = 4'b0001,
        OP_LOAD     = 4'b0010,
        OP_STORE    = 4'b0011,
        OP_CLEAR    = 4'b0100,
        OP_SKIPCOND = 4'b0101,
        OP_JUMP     = 4'b0110,
        OP_SUB      = 4'b0111,
        OP_AND      = 4'b1000,
        OP_OR       = 4'b1001,
        OP_NOT      = 4'b1010
    } opcode_e;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FETCH = 4'd1,
        ST_LDIR  = 4'd2,
        ST_DEC   = 4'd3,
        ST_OPA   = 4'd4,
        ST_OPD   = 4'd5,
        ST_EXE   = 4'd6,
        ST_WB    = 4'd7,
        ST_ST    = 4'd8,
        ST_HALT  = 4'd9
    } state_e;

    // Instruction classes as seen by the sequencer; CLS_NOP covers illegal words.
    typedef enum logic [3:0] {
        CLS_NOP   = 4'd0,
        CLS_ALU   = 4'd1,
        CLS_LOAD  = 4'd2,
        CLS_STORE = 4'd3,
        CLS_CLEAR = 4'd4,
        CLS_NOT   = 4'd5,
        CLS_JUMP  = 4'd6,
        CLS_SKIP  = 4'd7,
        CLS_HALT  = 4'd8
    } op_class_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b100;

    localparam logic [1:0] SKIP_NEG   = 2'b00;
    localparam logic [1:0] SKIP_ZERO  = 2'b01;
    localparam logic [1:0] SKIP_POS   = 2'b10;
    localparam logic [1:0] SKIP_NEVER = 2'b11;

    // Evaluate a SKIPCOND selector against the accumulator (signed compare).
    function automatic logic skip_taken(input logic [31:0] acc, input logic [1:0] sel);
        logic hit;
        case (sel)
            SKIP_NEG:   hit = acc[31];
            SKIP_ZERO:  hit = (acc == 32'd0);
            SKIP_POS:   hit = (!acc[31]) && (acc != 32'd0);
            SKIP_NEVER: hit = 1'b0;
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: maps the immediate flag and opcode
// field to an instruction class, ALU select and illegal indication.
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [4:0] ir_op,      // IR[31:27]: immediate flag + opcode
    output op_class_e  op_class,
    output logic       is_imm,
    output logic [2:0] alu_sel,
    output logic       illegal
);

    op_class_e cls_s;
    logic      imm_ok_s;

    // Classify the opcode and reject immediate forms of non-ALU opcodes.
    always_comb begin
        cls_s    = CLS_NOP;
        imm_ok_s = 1'b0;
        alu_sel  = ALU_ADD;
        is_imm   = ir_op[4];
        case (ir_op[3:0])
            OP_ADD:      begin cls_s = CLS_ALU; alu_sel = ALU_ADD; imm_ok_s = 1'b1; end
            OP_SUB:      begin cls_s = CLS_ALU; alu_sel = ALU_SUB; imm_ok_s = 1'b1; end
            OP_AND:      begin cls_s = CLS_ALU; alu_sel = ALU_AND; imm_ok_s = 1'b1; end
            OP_OR:       begin cls_s = CLS_ALU; alu_sel = ALU_OR;  imm_ok_s = 1'b1; end
            OP_HALT:     cls_s = CLS_HALT;
            OP_LOAD:     cls_s = CLS_LOAD;
            OP_STORE:    cls_s = CLS_STORE;
            OP_CLEAR:    cls_s = CLS_CLEAR;
            OP_SKIPCOND: cls_s = CLS_SKIP;
            OP_JUMP:     cls_s = CLS_JUMP;
            OP_NOT:      cls_s = CLS_NOT;
            default:     cls_s = CLS_NOP;
        endcase
        if ((cls_s == CLS_NOP) || (ir_op[4] && !imm_ok_s)) begin
            illegal  = 1'b1;
            op_class = CLS_NOP;
        end else begin
            illegal  = 1'b0;
            op_class = cls_s;
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Fetch/decode/execute controller for the 32-bit accumulator CPU. Owns
// PC/IR/MBR/AC and sequences the synchronous RAM and external ALU. All
// outputs are registered; memory controls are computed from the next
// state so they are valid in the cycle the state is entered.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 28,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(CPU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs,
    output logic                  mem_oe,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic [DATA_WIDTH-1:0] ir
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-2){1'b0}}, 2'd2};

    state_e                state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0] pc_r, pc_nxt_s;
    logic [DATA_WIDTH-1:0] ir_r, ir_nxt_s;
    logic [DATA_WIDTH-1:0] mbr_r, mbr_nxt_s;
    logic [DATA_WIDTH-1:0] ac_r, ac_nxt_s;
    logic [DATA_WIDTH-1:0] alu_a_r, alu_a_nxt_s;
    logic [DATA_WIDTH-1:0] alu_b_r, alu_b_nxt_s;
    logic [2:0]            alu_sel_r, alu_sel_nxt_s;
    logic                  illegal_r, illegal_nxt_s;

    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_nxt_s;
    logic                  mem_cs_r, mem_cs_nxt_s;
    logic                  mem_oe_r, mem_oe_nxt_s;
    logic                  mem_we_r, mem_we_nxt_s;
    logic [DATA_WIDTH-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic                  busy_r, halted_r;

    op_class_e             dec_class_s;
    logic                  dec_imm_s;
    logic [2:0]            dec_alu_sel_s;
    logic                  dec_illegal_s;
    logic [ADDR_WIDTH-1:0] ir_addr_s;
    logic [DATA_WIDTH-1:0] ir_imm_s;

    assign ir_addr_s = {{(ADDR_WIDTH-12){1'b0}}, ir_r[11:0]};
    assign ir_imm_s  = {{(DATA_WIDTH-12){1'b0}}, ir_r[11:0]};

    cpu_decoder u_decoder (
        .ir_op    (ir_r[31:27]),
        .op_class (dec_class_s),
        .is_imm   (dec_imm_s),
        .alu_sel  (dec_alu_sel_s),
        .illegal  (dec_illegal_s)
    );

    // Next-state and datapath register update logic.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        ir_nxt_s      = ir_r;
        mbr_nxt_s     = mbr_r;
        ac_nxt_s      = ac_r;
        alu_a_nxt_s   = alu_a_r;
        alu_b_nxt_s   = alu_b_r;
        alu_sel_nxt_s = alu_sel_r;
        illegal_nxt_s = illegal_r;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_nxt_s   = ST_FETCH;
                    illegal_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = state_r;
                end
            end
            ST_FETCH: state_nxt_s = ST_LDIR;
            ST_LDIR: begin
                ir_nxt_s    = mem_rdata;
                pc_nxt_s    = pc_r + PC_STEP;
                state_nxt_s = ST_DEC;
            end
            ST_DEC: begin
                state_nxt_s = ST_FETCH;
                case (dec_class_s)
                    CLS_ALU: begin
                        if (dec_imm_s) begin
                            state_nxt_s = ST_EXE;
                        end else begin
                            state_nxt_s = ST_OPA;
                        end
                    end
                    CLS_LOAD:  state_nxt_s = ST_OPA;
                    CLS_STORE: state_nxt_s = ST_ST;
                    CLS_CLEAR: ac_nxt_s    = {DATA_WIDTH{1'b0}};
                    CLS_NOT:   ac_nxt_s    = ~ac_r;
                    CLS_JUMP:  pc_nxt_s    = ir_addr_s;
                    CLS_SKIP: begin
                        if (skip_taken(ac_r, ir_r[11:10])) begin
                            pc_nxt_s = pc_r + PC_STEP;
                        end else begin
                            pc_nxt_s = pc_r;
                        end
                    end
                    CLS_HALT:  state_nxt_s = ST_HALT;
                    default:   illegal_nxt_s = illegal_r | dec_illegal_s;
                endcase
            end
            ST_OPA: state_nxt_s = ST_OPD;
            ST_OPD: begin
                mbr_nxt_s   = mem_rdata;
                state_nxt_s = (dec_class_s == CLS_LOAD) ? ST_WB : ST_EXE;
            end
            ST_EXE: begin
                alu_a_nxt_s   = ac_r;
                alu_b_nxt_s   = dec_imm_s ? ir_imm_s : mbr_r;
                alu_sel_nxt_s = dec_alu_sel_s;
                state_nxt_s   = ST_WB;
            end
            ST_WB: begin
                ac_nxt_s    = (dec_class_s == CLS_LOAD) ? mbr_r : alu_out;
                state_nxt_s = ST_FETCH;
            end
            ST_ST:   state_nxt_s = ST_FETCH;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Memory interface controls for the state about to be entered.
    always_comb begin
        mem_addr_nxt_s  = {ADDR_WIDTH{1'b0}};
        mem_cs_nxt_s    = 1'b0;
        mem_oe_nxt_s    = 1'b0;
        mem_we_nxt_s    = 1'b0;
        mem_wdata_nxt_s = {DATA_WIDTH{1'b0}};
        case (state_nxt_s)
            ST_FETCH: begin
                mem_addr_nxt_s = pc_nxt_s;
                mem_cs_nxt_s   = 1'b1;
                mem_oe_nxt_s   = 1'b1;
            end
            ST_OPA: begin
                mem_addr_nxt_s = ir_addr_s;
                mem_cs_nxt_s   = 1'b1;
                mem_oe_nxt_s   = 1'b1;
            end
            ST_ST: begin
                mem_addr_nxt_s  = ir_addr_s;
                mem_cs_nxt_s    = 1'b1;
                mem_we_nxt_s    = 1'b1;
                mem_wdata_nxt_s = ac_nxt_s;
            end
            default: mem_cs_nxt_s = 1'b0;
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            ir_r        <= {DATA_WIDTH{1'b0}};
            mbr_r       <= {DATA_WIDTH{1'b0}};
            ac_r        <= {DATA_WIDTH{1'b0}};
            alu_a_r     <= {DATA_WIDTH{1'b0}};
            alu_b_r     <= {DATA_WIDTH{1'b0}};
            alu_sel_r   <= 3'b000;
            illegal_r   <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_cs_r    <= 1'b0;
            mem_oe_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            ir_r        <= ir_nxt_s;
            mbr_r       <= mbr_nxt_s;
            ac_r        <= ac_nxt_s;
            alu_a_r     <= alu_a_nxt_s;
            alu_b_r     <= alu_b_nxt_s;
            alu_sel_r   <= alu_sel_nxt_s;
            illegal_r   <= illegal_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_cs_r    <= mem_cs_nxt_s;
            mem_oe_r    <= mem_oe_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_HALT);
            halted_r    <= (state_nxt_s == ST_HALT);
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_cs    = mem_cs_r;
    assign mem_oe    = mem_oe_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = mem_wdata_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_sel   = alu_sel_r;
    assign busy      = busy_r;
    assign halted    = halted_r;
    assign illegal   = illegal_r;
    assign pc        = pc_r;
    assign ac        = ac_r;
    assign ir        = ir_r;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: synchronous RAM and ALU models,
// a loader port, and a scoreboard of per-instruction expectations that is
// consumed at each FETCH boundary.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [27:0] mem_addr;
    logic        mem_cs, mem_oe, mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_sel;
    logic        busy, halted, illegal;
    logic [27:0] pc;
    logic [31:0] ac, ir;

    logic [31:0] ram [0:4095];
    logic        ld_we = 1'b0;
    logic [11:0] ld_addr = 12'd0;
    logic [31:0] ld_data = 32'd0;
    int          wr_count = 0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          lat;
        logic [31:0] ac;
        logic [27:0] pc;
        bit          halt;
        bit          ill;
    } exp_t;
    exp_t exp_q[$];

    cpu_ctrl_fsm #(.ADDR_WIDTH(28), .DATA_WIDTH(32), .RESET_PC(28'h100)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .busy(busy), .halted(halted), .illegal(illegal),
        .pc(pc), .ac(ac), .ir(ir)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM; the loader port wins when active.
    always @(posedge clk) begin
        if (ld_we) begin
            ram[ld_addr] <= ld_data;
        end else if (mem_cs && mem_we) begin
            ram[mem_addr[11:0]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (mem_cs && mem_oe) mem_rdata <= ram[mem_addr[11:0]];
    end

    // External ALU reference.
    always_comb begin
        case (alu_sel)
            3'b000:  alu_out = alu_a & alu_b;
            3'b001:  alu_out = alu_a + alu_b;
            3'b010:  alu_out = alu_a - alu_b;
            3'b100:  alu_out = alu_a | alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    task automatic load_word(input logic [27:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a[11:0]; ld_data = d;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    // Returns one ns after the edge that moves IDLE/HALT into FETCH.
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic expect_step(input int lat, input logic [31:0] a, input logic [27:0] p,
                               input bit h, input bit il);
        exp_t e;
        e.lat = lat; e.ac = a; e.pc = p; e.halt = h; e.ill = il;
        exp_q.push_back(e);
    endtask

    // Scoreboard consumer: waits each instruction's latency, then compares.
    task automatic run_expected(input string tag);
        exp_t e;
        int   k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            repeat (e.lat) @(posedge clk);
            #1;
            checks++; if (ac !== e.ac) begin errors++; $display("FAIL %s[%0d] ac: got %h want %h", tag, k, ac, e.ac); end
            checks++; if (pc !== e.pc) begin errors++; $display("FAIL %s[%0d] pc: got %h want %h", tag, k, pc, e.pc); end
            checks++; if (halted !== e.halt) begin errors++; $display("FAIL %s[%0d] halted: got %b want %b", tag, k, halted, e.halt); end
            checks++; if (illegal !== e.ill) begin errors++; $display("FAIL %s[%0d] illegal: got %b want %b", tag, k, illegal, e.ill); end
            if (!e.halt) begin
                checks++; if (mem_addr !== e.pc || mem_cs !== 1'b1 || mem_oe !== 1'b1 || busy !== 1'b1) begin
                    errors++; $display("FAIL %s[%0d] fetch: got addr %h cs %b oe %b busy %b want addr %h cs 1 oe 1 busy 1",
                                       tag, k, mem_addr, mem_cs, mem_oe, busy, e.pc);
                end
            end else begin
                checks++; if (busy !== 1'b0 || mem_cs !== 1'b0) begin
                    errors++; $display("FAIL %s[%0d] halt quiet: got busy %b cs %b want 0 0", tag, k, busy, mem_cs);
                end
            end
            k++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++; if (pc !== 28'h100) begin errors++; $display("FAIL rst_pc: got %h want 100", pc); end
        checks++; if (ac !== 32'd0) begin errors++; $display("FAIL rst_ac: got %h want 0", ac); end
        checks++; if (ir !== 32'd0) begin errors++; $display("FAIL rst_ir: got %h want 0", ir); end
        checks++; if (mem_cs !== 1'b0 || mem_oe !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_ctl: got %b%b%b want 000", mem_cs, mem_oe, mem_we); end
        checks++; if (mem_addr !== 28'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_bus: got %h %h want 0 0", mem_addr, mem_wdata); end
        checks++; if (busy !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL rst_flags: got %b%b%b want 000", busy, halted, illegal); end
        checks++; if (alu_sel !== 3'b000 || alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("FAIL rst_alu: got %b %h %h want 000 0 0", alu_sel, alu_a, alu_b); end
        @(negedge clk); rst_n = 1'b1;
        load_word(28'h100, 32'h0800_0000);
        pulse_start();
        checks++; if (mem_addr !== 28'h100 || mem_cs !== 1'b1 || mem_oe !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL start_fetch: got addr %h cs%b oe%b we%b want 100 1 1 0", mem_addr, mem_cs, mem_oe, mem_we);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
        // A start pulse while busy must not disturb the running HALT.
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++; if (halted !== 1'b1 || pc !== 28'h102) begin errors++; $display("FAIL halt_only: got halted %b pc %h want 1 102", halted, pc); end
    endtask

    task automatic test_program();
        int wc0;
        reset_dut();
        load_word(28'h120, 32'd5);
        load_word(28'h122, 32'd7);
        load_word(28'h124, 32'd0);
        load_word(28'h100, 32'h1000_0120);
        load_word(28'h102, 32'h0000_0122);
        load_word(28'h104, 32'h1800_0124);
        load_word(28'h106, 32'h0800_0000);
        expect_step(6, 32'd5,  28'h102, 1'b0, 1'b0);
        expect_step(7, 32'd12, 28'h104, 1'b0, 1'b0);
        expect_step(4, 32'd12, 28'h106, 1'b0, 1'b0);
        expect_step(3, 32'd12, 28'h108, 1'b1, 1'b0);
        wc0 = wr_count;
        pulse_start();
        run_expected("prog");
        checks++; if (ram[12'h124] !== 32'd12) begin errors++; $display("FAIL prog_store: got %h want 0000000c", ram[12'h124]); end
        checks++; if (wr_count !== wc0 + 1) begin errors++; $display("FAIL prog_wr_count: got %0d want %0d", wr_count - wc0, 1); end
    endtask

    task automatic test_imm_skip();
        reset_dut();
        load_word(28'h100, 32'h8000_000A);
        load_word(28'h102, 32'hB800_000B);
        load_word(28'h104, 32'h2800_0000);
        load_word(28'h106, 32'h8000_0001);
        load_word(28'h108, 32'h2000_0000);
        load_word(28'h10A, 32'h2800_0800);
        load_word(28'h10C, 32'h2800_0400);
        load_word(28'h10E, 32'h8000_0001);
        load_word(28'h110, 32'h5000_0000);
        load_word(28'h112, 32'h3000_0200);
        load_word(28'h200, 32'h0800_0000);
        expect_step(5, 32'h0000_000A, 28'h102, 1'b0, 1'b0);
        expect_step(5, 32'hFFFF_FFFF, 28'h104, 1'b0, 1'b0);
        expect_step(3, 32'hFFFF_FFFF, 28'h108, 1'b0, 1'b0);
        expect_step(3, 32'h0000_0000, 28'h10A, 1'b0, 1'b0);
        expect_step(3, 32'h0000_0000, 28'h10C, 1'b0, 1'b0);
        expect_step(3, 32'h0000_0000, 28'h110, 1'b0, 1'b0);
        expect_step(3, 32'hFFFF_FFFF, 28'h112, 1'b0, 1'b0);
        expect_step(3, 32'hFFFF_FFFF, 28'h200, 1'b0, 1'b0);
        expect_step(3, 32'hFFFF_FFFF, 28'h202, 1'b1, 1'b0);
        pulse_start();
        run_expected("imm");
    endtask

    task automatic test_logic_illegal();
        reset_dut();
        load_word(28'h130, 32'hF0F0_00FF);
        load_word(28'h132, 32'h0F00_0F0F);
        load_word(28'h134, 32'hFFFF_F0F1);
        load_word(28'h100, 32'h8000_0FFF);
        load_word(28'h102, 32'h4000_0130);
        load_word(28'h104, 32'h4800_0132);
        load_word(28'h106, 32'hC000_0F0F);
        load_word(28'h108, 32'hF800_0000);
        load_word(28'h10A, 32'h9000_0000);
        load_word(28'h10C, 32'h0000_0134);
        load_word(28'h10E, 32'h0800_0000);
        load_word(28'h110, 32'h0800_0000);
        expect_step(5, 32'h0000_0FFF, 28'h102, 1'b0, 1'b0);
        expect_step(7, 32'h0000_00FF, 28'h104, 1'b0, 1'b0);
        expect_step(7, 32'h0F00_0FFF, 28'h106, 1'b0, 1'b0);
        expect_step(5, 32'h0000_0F0F, 28'h108, 1'b0, 1'b0);
        expect_step(3, 32'h0000_0F0F, 28'h10A, 1'b0, 1'b1);
        expect_step(3, 32'h0000_0F0F, 28'h10C, 1'b0, 1'b1);
        expect_step(7, 32'h0000_0000, 28'h10E, 1'b0, 1'b1);
        expect_step(3, 32'h0000_0000, 28'h110, 1'b1, 1'b1);
        pulse_start();
        run_expected("logic");
        pulse_start();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_clear: got %b want 0", illegal); end
        checks++; if (mem_addr !== 28'h110) begin errors++; $display("FAIL resume_addr: got %h want 110", mem_addr); end
        expect_step(3, 32'h0000_0000, 28'h112, 1'b1, 1'b0);
        run_expected("resume");
    endtask

    task automatic test_store_reset();
        int wc0;
        reset_dut();
        load_word(28'h140, 32'hDEAD_BEEF);
        load_word(28'h100, 32'h8000_0055);
        load_word(28'h102, 32'h1800_0140);
        expect_step(5, 32'h0000_0055, 28'h102, 1'b0, 1'b0);
        wc0 = wr_count;
        pulse_start();
        run_expected("st");
        repeat (3) @(posedge clk); #1;
        checks++; if (mem_we !== 1'b1 || mem_cs !== 1'b1 || mem_oe !== 1'b0) begin errors++; $display("FAIL st_ctl: got cs%b oe%b we%b want 1 0 1", mem_cs, mem_oe, mem_we); end
        checks++; if (mem_addr !== 28'h140 || mem_wdata !== 32'h55) begin errors++; $display("FAIL st_bus: got %h %h want 140 00000055", mem_addr, mem_wdata); end
        #2; rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_cs !== 1'b0 || mem_addr !== 28'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL st_async: got we%b cs%b addr %h wdata %h want 0 0 0 0", mem_we, mem_cs, mem_addr, mem_wdata);
        end
        checks++; if (pc !== 28'h100 || ac !== 32'd0 || ir !== 32'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL st_regs: got pc %h ac %h ir %h busy %b want 100 0 0 0", pc, ac, ir, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        checks++; if (ram[12'h140] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_target: got %h want deadbeef", ram[12'h140]); end
        checks++; if (wr_count !== wc0) begin errors++; $display("FAIL st_writes: got %0d want 0", wr_count - wc0); end
        repeat (3) @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || mem_cs !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL st_idle: got busy %b cs %b halted %b want 0 0 0", busy, mem_cs, halted);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_imm_skip();
        test_logic_illegal();
        test_store_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
